// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: pipeline-control request/response bundle between the pipeline and pipe_ctrl
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        div_start;
  logic        stallreq_mem;
  logic        flush_req;
  logic [31:0] exc_pc;
  logic [3:0]  hold;
  logic [3:0]  bubble;
  logic        flush;
  logic [31:0] new_pc;
  logic        div_busy;
  logic        div_done;
  logic [31:0] stall_cycles;
  modport master (
    output stallreq_if, stallreq_id, div_start, stallreq_mem, flush_req, exc_pc,
    input  hold, bubble, flush, new_pc, div_busy, div_done, stall_cycles
  );
  modport slave (
    input  stallreq_if, stallreq_id, div_start, stallreq_mem, flush_req, exc_pc,
    output hold, bubble, flush, new_pc, div_busy, div_done, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hold/bubble/flush control with multi-cycle divide stall; PIPE_STALL_CNT_EN enables the stall counter
module pipe_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [5:0] CNT_INIT = 6'(DIV_CYCLES - 1);
  logic [0:0] state;
  logic [5:0] cnt;
  logic       div_stall;
  logic       any_stall;
  logic [1:0] lvl;
  logic       quiet;
  // priority-encode the stall sources and build the hold/bubble patterns
  always_comb begin
    div_stall = !bus.flush_req && (state == IDLE ? bus.div_start : cnt != 6'd0);
    lvl = bus.stallreq_mem ? 2'd3 : div_stall ? 2'd2 : bus.stallreq_id ? 2'd1 : 2'd0;
    any_stall = bus.stallreq_mem | div_stall | bus.stallreq_id | bus.stallreq_if;
    quiet = !rst || bus.flush_req;
    bus.hold = quiet ? 4'd0 : any_stall ? 4'((5'd2 << lvl) - 5'd1) : 4'd0;
    bus.bubble = quiet ? 4'hF : any_stall ? 4'd1 << lvl : 4'd0;
    bus.flush = rst && bus.flush_req;
    bus.new_pc = (rst && bus.flush_req) ? bus.exc_pc : 32'd0;
    bus.div_busy = rst && state == BUSY;
    bus.div_done = rst && state == BUSY && cnt == 6'd0 && !bus.flush_req;
  end
  // divider occupancy FSM; flush or reset abandons an in-flight divide
  always_ff @(posedge clk) begin
    if (!rst || bus.flush_req) begin
      state <= IDLE;
      cnt <= 6'd0;
    end else if (state == IDLE) begin
      if (bus.div_start) begin
        state <= BUSY;
        cnt <= CNT_INIT;
      end
    end else if (cnt != 6'd0) begin
      cnt <= cnt - 6'd1;
    end else begin
      state <= IDLE;
    end
  end
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt;
  // count cycles in which the PC is held
  always_ff @(posedge clk) begin
    if (!rst) stall_cnt <= 32'd0;
    else if (bus.hold[0]) stall_cnt <= stall_cnt + 32'd1;
  end
  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl with DIV_CYCLES=4
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
`ifdef PIPE_STALL_CNT_EN
  localparam logic [31:0] EXP_CNT = 32'd5;
`else
  localparam logic [31:0] EXP_CNT = 32'd0;
`endif
  pipe_ctrl_if bus ();
  pipe_ctrl #(.DIV_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  // v = {flush_req, stallreq_mem, div_start, stallreq_id, stallreq_if}
  task automatic cyc(input logic r, input logic [4:0] v);
    @(posedge clk);
    #1;
    rst = r;
    {bus.flush_req, bus.stallreq_mem, bus.div_start, bus.stallreq_id, bus.stallreq_if} = v;
    #2;
  endtask
  task automatic chk_hb(input string tag, input logic [3:0] h, input logic [3:0] b);
    chk({tag, ".hold"}, 32'(bus.hold), 32'(h));
    chk({tag, ".bubble"}, 32'(bus.bubble), 32'(b));
  endtask
  task automatic chk_div(input string tag, input logic busy, input logic done);
    chk({tag, ".busy"}, 32'(bus.div_busy), 32'(busy));
    chk({tag, ".done"}, 32'(bus.div_done), 32'(done));
  endtask
  initial begin
    bus.exc_pc = 32'h0000_0180;
    {bus.flush_req, bus.stallreq_mem, bus.div_start, bus.stallreq_id, bus.stallreq_if} = 5'b0;
    cyc(1'b0, 5'b00000);
    cyc(1'b0, 5'b11111);
    chk_hb("rst", 4'h0, 4'hF);
    chk("rst.flush", 32'(bus.flush), 32'd0);
    chk("rst.new_pc", bus.new_pc, 32'd0);
    chk_div("rst", 1'b0, 1'b0);
    cyc(1'b1, 5'b00000);
    chk_hb("idle", 4'h0, 4'h0);
    chk("idle.flush", 32'(bus.flush), 32'd0);
    chk("idle.new_pc", bus.new_pc, 32'd0);
    chk_div("idle", 1'b0, 1'b0);
    chk("idle.cnt", bus.stall_cycles, 32'd0);
    cyc(1'b1, 5'b00001);
    chk_hb("if", 4'b0001, 4'b0001);
    cyc(1'b1, 5'b00010);
    chk_hb("id", 4'b0011, 4'b0010);
    cyc(1'b1, 5'b00000);
    chk_hb("id_after", 4'h0, 4'h0);
    cyc(1'b1, 5'b01011);
    chk_hb("mem", 4'b1111, 4'b1000);
    cyc(1'b1, 5'b11000);
    chk_hb("flush", 4'h0, 4'hF);
    chk("flush.flush", 32'(bus.flush), 32'd1);
    chk("flush.new_pc", bus.new_pc, 32'h180);
    cyc(1'b1, 5'b00000);
    chk("flush_after.flush", 32'(bus.flush), 32'd0);
    chk_div("flush_after", 1'b0, 1'b0);
    // plain divide, div_start held through the done cycle
    cyc(1'b1, 5'b00100);
    chk_hb("div0", 4'b0111, 4'b0100);
    chk_div("div0", 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b1, 5'b00100);
      chk_hb($sformatf("div%0d", i), 4'b0111, 4'b0100);
      chk_div($sformatf("div%0d", i), 1'b1, 1'b0);
    end
    cyc(1'b1, 5'b00100);
    chk_hb("div4", 4'h0, 4'h0);
    chk_div("div4", 1'b1, 1'b1);
    cyc(1'b1, 5'b00000);
    chk_div("div5", 1'b0, 1'b0);
    chk_hb("div5", 4'h0, 4'h0);
    // MEM stall overriding a busy divider
    cyc(1'b1, 5'b00100);
    cyc(1'b1, 5'b01000);
    chk_hb("dm1", 4'b1111, 4'b1000);
    chk_div("dm1", 1'b1, 1'b0);
    cyc(1'b1, 5'b01000);
    chk_hb("dm2", 4'b1111, 4'b1000);
    cyc(1'b1, 5'b00000);
    chk_hb("dm3", 4'b0111, 4'b0100);
    cyc(1'b1, 5'b01000);
    chk_hb("dm4", 4'b1111, 4'b1000);
    chk_div("dm4", 1'b1, 1'b1);
    cyc(1'b1, 5'b00000);
    chk_div("dm5", 1'b0, 1'b0);
    // flush with cnt=2 abandons the divide
    cyc(1'b1, 5'b00100);
    cyc(1'b1, 5'b00000);
    cyc(1'b1, 5'b10000);
    chk_div("fl2", 1'b1, 1'b0);
    chk_hb("fl2", 4'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 5'b00000);
      chk_div($sformatf("fl_post%0d", i), 1'b0, 1'b0);
    end
    cyc(1'b1, 5'b00100);
    chk_hb("restart", 4'b0111, 4'b0100);
    cyc(1'b1, 5'b00000);
    chk_div("restart1", 1'b1, 1'b0);
    cyc(1'b1, 5'b00000);
    cyc(1'b1, 5'b00000);
    cyc(1'b1, 5'b10000);
    chk_div("fl0", 1'b1, 1'b0);
    cyc(1'b1, 5'b00000);
    chk_div("fl0_after", 1'b0, 1'b0);
    // reset mid-divide
    cyc(1'b1, 5'b00100);
    cyc(1'b1, 5'b00000);
    chk_div("rd1", 1'b1, 1'b0);
    cyc(1'b0, 5'b00000);
    chk_div("rd_rst", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 5'b00000);
      chk_div($sformatf("rd_post%0d", i), 1'b0, 1'b0);
    end
    // stall counter
    cyc(1'b0, 5'b00000);
    for (int i = 0; i < 5; i++) cyc(1'b1, 5'b00001);
    cyc(1'b1, 5'b00000);
    chk("cnt5", bus.stall_cycles, EXP_CNT);
    cyc(1'b0, 5'b00000);
    cyc(1'b1, 5'b00000);
    chk("cnt_rst", bus.stall_cycles, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
